// File: rtl/pasta_pkg.sv
// rtl/pasta_pkg.sv - shared PASTA datapath constants and op encodings
//
// Purpose: parameter defaults for the PASTA modular datapath blocks and the
//          add/sub operation encoding used on in_op.
// Contents: PASTA_BITLEN, PASTA_Q, PASTA_S, OP_ADD, OP_SUB.
package pasta_pkg;

    localparam int PASTA_BITLEN = 17;
    localparam int PASTA_Q      = 65537;
    localparam int PASTA_S      = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/modaddsub_lane.sv
// rtl/modaddsub_lane.sv - one lane of the pipelined modular adder/subtractor
//
// Purpose: stage-1 raw sum (a+b or a+(Q-b)), stage-2 conditional subtract of Q,
//          and a combinational range flag for the current operands.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   s1_en        capture raw value from a/b/op
//   s2_en        capture corrected result from the raw register
//   op           0 = add, 1 = subtract
//   a, b         lane operands (expected in [0, Q-1])
//   res          registered lane result in [0, Q-1]
//   range_err    a >= Q or b >= Q (combinational, for the current operands)
module modaddsub_lane
    import pasta_pkg::*;
#(
    parameter int BITLEN = PASTA_BITLEN,
    parameter int Q      = PASTA_Q
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s1_en,
    input  logic              s2_en,
    input  logic              op,
    input  logic [BITLEN-1:0] a,
    input  logic [BITLEN-1:0] b,
    output logic [BITLEN-1:0] res,
    output logic              range_err
);

    localparam logic [BITLEN:0]   Q_W  = (BITLEN + 1)'(Q);
    localparam logic [BITLEN-1:0] Q_LO = BITLEN'(Q);

    logic [BITLEN:0]   a_x;
    logic [BITLEN:0]   b_x;
    logic [BITLEN:0]   addend;
    logic [BITLEN:0]   raw_nxt;
    logic [BITLEN:0]   raw;
    logic [BITLEN-1:0] corr;

    assign a_x = {1'b0, a};
    assign b_x = {1'b0, b};

    // Subtraction is a + (Q - b): for in-range b this never goes negative,
    // so one correction step in stage 2 is enough for both modes.
    assign addend  = (op == OP_SUB) ? (Q_W - b_x) : b_x;
    assign raw_nxt = a_x + addend;

    assign range_err = (a_x >= Q_W) || (b_x >= Q_W);

    // Only the low bits of raw - Q survive, so the subtract is done at lane width.
    assign corr = raw[BITLEN-1:0] - Q_LO;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw <= '0;
        end else if (s1_en) begin
            raw <= raw_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= '0;
        end else if (s2_en) begin
            res <= (raw >= Q_W) ? corr : raw[BITLEN-1:0];
        end
    end

endmodule

// File: rtl/modaddsub_vec_pipe.sv
// rtl/modaddsub_vec_pipe.sv - two-stage vector modular add/sub with valid/ready
//
// Purpose: LANES-wide modular a+b / a-b mod Q, two register stages, full
//          backpressure, sticky operand range-error flag.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     input vector valid
//   in_ready     input accepted this cycle (combinational)
//   in_op        0 = add, 1 = subtract
//   in_a, in_b   packed operands, lane i at [BITLEN*(i+1)-1 : BITLEN*i]
//   out_valid    result valid
//   out_ready    consumer accepts result
//   out_res      packed result vector
//   err          sticky: an accepted operand lane was >= Q
//   err_clr      synchronous clear of err (a same-cycle set wins)
module modaddsub_vec_pipe
    import pasta_pkg::*;
#(
    parameter int BITLEN = PASTA_BITLEN,
    parameter int Q      = PASTA_Q,
    parameter int LANES  = PASTA_S
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_op,
    input  logic [BITLEN*LANES-1:0] in_a,
    input  logic [BITLEN*LANES-1:0] in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BITLEN*LANES-1:0] out_res,
    output logic                    err,
    input  logic                    err_clr
);

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_load;
    logic             s2_load;
    logic             in_fire;
    logic             s2_en;
    logic [LANES-1:0] lane_err;

    // An empty stage always loads, so bubbles collapse even under backpressure.
    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign in_fire  = in_valid && s1_load;
    assign s2_en    = s2_load && s1_valid;

    assign out_valid = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (in_fire && (|lane_err)) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        modaddsub_lane #(
            .BITLEN (BITLEN),
            .Q      (Q)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .s1_en     (in_fire),
            .s2_en     (s2_en),
            .op        (in_op),
            .a         (in_a[BITLEN*i +: BITLEN]),
            .b         (in_b[BITLEN*i +: BITLEN]),
            .res       (out_res[BITLEN*i +: BITLEN]),
            .range_err (lane_err[i])
        );
    end

endmodule
